// File: rtl/rgb_led_scheduler.sv
// rtl/rgb_led_scheduler.sv - round-robin owner of the shared RGB LED with minimum hold and PWM brightness
module rgb_led_scheduler #(
  parameter logic [31:0] HOLD_CYCLES = 32'd16777216,
  parameter int          PWM_BITS    = 8
) (
  input  logic                    sys_clock,
  input  logic                    sys_resetn,
  input  logic [2:0]              req,
  input  logic [8:0]              req_color,
  input  logic [3*PWM_BITS-1:0]   req_level,
  output logic [2:0]              grant,
  output logic                    busy,
  output logic                    rgb_led_tri_o_0,
  output logic                    rgb_led_tri_o_1,
  output logic                    rgb_led_tri_o_2
);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t                state, state_next;
  logic [2:0]            grant_next;
  logic [1:0]            last_grant, last_next;
  logic [31:0]           hold_cnt, hold_next;
  logic [2:0]            color_q, color_next;
  logic [PWM_BITS-1:0]   level_q, level_next;
  logic [PWM_BITS-1:0]   pwm_cnt;
  logic [2:0]            led_q;

  logic [1:0]            owner_idx;
  logic [1:0]            search_from;
  logic                  found;
  logic [1:0]            winner;
  logic [2:0]            winner_color;
  logic [PWM_BITS-1:0]   winner_level;

  function automatic logic [1:0] next_idx(input logic [1:0] i);
    return (i == 2'd2) ? 2'd0 : i + 2'd1;
  endfunction

  always_comb begin
    owner_idx = 2'd0;
    if (grant[1]) owner_idx = 2'd1;
    if (grant[2]) owner_idx = 2'd2;
  end

  // The search always starts just past the most recent owner, so the owner itself is tried last.
  always_comb begin
    logic [1:0] idx;
    search_from = (state == HOLD) ? next_idx(owner_idx) : next_idx(last_grant);
    found       = 1'b0;
    winner      = 2'd0;
    idx         = search_from;
    for (int k = 0; k < 3; k++) begin
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
      idx = next_idx(idx);
    end
  end

  always_comb begin
    winner_color = req_color[2:0];
    winner_level = req_level[PWM_BITS-1:0];
    case (winner)
      2'd1: begin
        winner_color = req_color[5:3];
        winner_level = req_level[2*PWM_BITS-1:PWM_BITS];
      end
      2'd2: begin
        winner_color = req_color[8:6];
        winner_level = req_level[3*PWM_BITS-1:2*PWM_BITS];
      end
      default: ;
    endcase
  end

  always_comb begin
    state_next = state;
    grant_next = grant;
    last_next  = last_grant;
    hold_next  = hold_cnt;
    color_next = color_q;
    level_next = level_q;
    case (state)
      IDLE: begin
        if (found) begin
          state_next = HOLD;
          grant_next = 3'b001 << winner;
          color_next = winner_color;
          level_next = winner_level;
          hold_next  = HOLD_CYCLES - 32'd1;
        end
      end
      HOLD: begin
        if (hold_cnt != 32'd0) begin
          hold_next = hold_cnt - 32'd1;
        end else begin
          last_next = owner_idx;
          if (found) begin
            grant_next = 3'b001 << winner;
            color_next = winner_color;
            level_next = winner_level;
            hold_next  = HOLD_CYCLES - 32'd1;
          end else begin
            state_next = IDLE;
            grant_next = 3'b000;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge sys_clock) begin
    if (!sys_resetn) begin
      state      <= IDLE;
      grant      <= 3'b000;
      busy       <= 1'b0;
      last_grant <= 2'd2;
      hold_cnt   <= 32'd0;
      color_q    <= 3'b000;
      level_q    <= '0;
      pwm_cnt    <= '0;
      led_q      <= 3'b000;
    end else begin
      state      <= state_next;
      grant      <= grant_next;
      busy       <= |grant_next;
      last_grant <= last_next;
      hold_cnt   <= hold_next;
      color_q    <= color_next;
      level_q    <= level_next;
      pwm_cnt    <= pwm_cnt + 1'b1;
      led_q      <= {3{busy}} & color_q & {3{pwm_cnt < level_q}};
    end
  end

  assign rgb_led_tri_o_0 = led_q[0];
  assign rgb_led_tri_o_1 = led_q[1];
  assign rgb_led_tri_o_2 = led_q[2];

endmodule

// File: tb/tb_rgb_led_scheduler.sv
// tb/tb_rgb_led_scheduler.sv - directed and randomized checks of rgb_led_scheduler against a cycle model
module tb_rgb_led_scheduler;
  localparam int H = 4;

  logic        sys_clock = 1'b0;
  logic        sys_resetn;
  logic [2:0]  req;
  logic [8:0]  req_color;
  logic [23:0] req_level;
  logic [2:0]  grant;
  logic        busy;
  logic        rgb_led_tri_o_0, rgb_led_tri_o_1, rgb_led_tri_o_2;

  int passed = 0;
  int total  = 0;

  // Model: owner index (-1 idle), cycles the owner has been shown, latched colour/level.
  int         m_owner = -1;
  int         m_last  = 2;
  int         m_age   = 0;
  int         m_pwm   = 0;
  int         m_level = 0;
  logic [2:0] m_color = 3'b000;
  logic [2:0] m_pins  = 3'b000;

  always #5 sys_clock = ~sys_clock;

  rgb_led_scheduler #(.HOLD_CYCLES(32'(H)), .PWM_BITS(8)) dut (
    .sys_clock       (sys_clock),
    .sys_resetn      (sys_resetn),
    .req             (req),
    .req_color       (req_color),
    .req_level       (req_level),
    .grant           (grant),
    .busy            (busy),
    .rgb_led_tri_o_0 (rgb_led_tri_o_0),
    .rgb_led_tri_o_1 (rgb_led_tri_o_1),
    .rgb_led_tri_o_2 (rgb_led_tri_o_2)
  );

  function automatic int pick(input logic [2:0] r, input int from);
    for (int k = 0; k < 3; k++) begin
      if (r[(from + k) % 3]) return (from + k) % 3;
    end
    return -1;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic give(input int p);
    m_owner = p;
    m_last  = p;
    m_color = req_color[3*p +: 3];
    m_level = int'(req_level[8*p +: 8]);
    m_age   = 1;
  endtask

  task automatic model_edge();
    logic [2:0] np;
    int p;
    if (!sys_resetn) begin
      m_owner = -1; m_last = 2; m_age = 0; m_pwm = 0; m_pins = 3'b000;
      m_color = 3'b000; m_level = 0;
    end else begin
      for (int c = 0; c < 3; c++) np[c] = (m_owner >= 0) && m_color[c] && (m_pwm < m_level);
      m_pwm = (m_pwm + 1) % 256;
      if (m_owner < 0) begin
        p = pick(req, (m_last + 1) % 3);
        if (p >= 0) give(p);
      end else if (m_age < H) begin
        m_age = m_age + 1;
      end else begin
        p = pick(req, (m_owner + 1) % 3);
        if (p >= 0) give(p);
        else m_owner = -1;
      end
      m_pins = np;
    end
  endtask

  function automatic logic [2:0] pins();
    return {rgb_led_tri_o_2, rgb_led_tri_o_1, rgb_led_tri_o_0};
  endfunction

  task automatic step();
    @(posedge sys_clock);
    model_edge();
    #1;
    check("model_grant", 32'(grant), (m_owner < 0) ? 32'd0 : (32'd1 << m_owner));
    check("model_busy", 32'(busy), 32'(m_owner >= 0));
    check("model_pins", 32'(pins()), 32'(m_pins));
  endtask

  task automatic do_reset();
    sys_resetn = 1'b0;
    step();
    step();
    sys_resetn = 1'b1;
  endtask

  initial begin
    logic [2:0] rot [4];
    int on_r, on_g, on_b;
    rot[0] = 3'b001; rot[1] = 3'b010; rot[2] = 3'b100; rot[3] = 3'b001;

    // Reset held with all requests pending.
    sys_resetn = 1'b0;
    req        = 3'b111;
    req_color  = 9'o777;
    req_level  = 24'hFFFFFF;
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_grant", 32'(grant), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_pins", 32'(pins()), 32'd0);
    end
    sys_resetn = 1'b1;
    step();
    check("release_grant", 32'(grant), 32'd1);

    // Round-robin with all three requesting, H cycles each.
    for (int i = 0; i < 4 * H; i++) begin
      check("rotation", 32'(grant), 32'(rot[i / H]));
      step();
    end

    // Single requester, red at half brightness.
    do_reset();
    req       = 3'b010;
    req_color = 9'b000_001_000;
    req_level = 24'h00_80_00;
    step();
    check("single_grant", 32'(grant), 32'b010);
    step(); step();
    on_r = 0; on_g = 0; on_b = 0;
    for (int i = 0; i < 256; i++) begin
      step();
      on_r += int'(rgb_led_tri_o_0); on_g += int'(rgb_led_tri_o_1); on_b += int'(rgb_led_tri_o_2);
    end
    check("lvl128_red", 32'(on_r), 32'd128);
    check("lvl128_green", 32'(on_g), 32'd0);
    check("lvl128_blue", 32'(on_b), 32'd0);

    // Early drop: grant must persist for the full hold.
    do_reset();
    req       = 3'b001;
    req_color = 9'o007;
    req_level = 24'h0000C8;
    step();
    check("drop_grant0", 32'(grant), 32'b001);
    req = 3'b000;
    for (int i = 1; i < H; i++) begin
      step();
      check("drop_hold", 32'(grant), 32'b001);
    end
    step();
    check("drop_idle_grant", 32'(grant), 32'd0);
    check("drop_idle_busy", 32'(busy), 32'd0);
    step();
    check("drop_idle_pins", 32'(pins()), 32'd0);

    // Level boundaries, white.
    do_reset();
    req = 3'b001; req_color = 9'o007; req_level = 24'h000000;
    on_r = 0;
    for (int i = 0; i < 260; i++) begin
      step();
      on_r += int'(rgb_led_tri_o_0) + int'(rgb_led_tri_o_1) + int'(rgb_led_tri_o_2);
    end
    check("lvl0_pins", 32'(on_r), 32'd0);
    req_level = 24'h0000FF;
    for (int i = 0; i < 2 * H; i++) step();
    on_r = 0; on_g = 0; on_b = 0;
    for (int i = 0; i < 256; i++) begin
      step();
      on_r += int'(rgb_led_tri_o_0); on_g += int'(rgb_led_tri_o_1); on_b += int'(rgb_led_tri_o_2);
    end
    check("lvl255_red", 32'(on_r), 32'd255);
    check("lvl255_green", 32'(on_g), 32'd255);
    check("lvl255_blue", 32'(on_b), 32'd255);

    // Renewal: a colour change mid-hold shows only after re-latch.
    do_reset();
    req = 3'b100; req_color = 9'b001_000_000; req_level = 24'hFF0000;
    step();
    check("renew_grant", 32'(grant), 32'b100);
    step();
    req_color = 9'b110_000_000;
    step();
    check("renew_old_color_a", 32'(pins()), 32'b001);
    step();
    check("renew_old_color_b", 32'(pins()), 32'b001);
    step();
    check("renew_keep_grant", 32'(grant), 32'b100);
    check("renew_old_color_c", 32'(pins()), 32'b001);
    step();
    check("renew_new_color", 32'(pins()), 32'b110);
    sys_resetn = 1'b0;
    step();
    check("midrst_grant", 32'(grant), 32'd0);
    check("midrst_pins", 32'(pins()), 32'd0);
    sys_resetn = 1'b1;

    // Randomized traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 3) == 0) req = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 7) == 0) req_color = 9'($urandom);
      if ($urandom_range(0, 7) == 0) req_level = 24'($urandom);
      sys_resetn = ($urandom_range(0, 299) != 0);
      step();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/rgb_led_scheduler.md
Name: rgb_led_scheduler

Overview:
- Shares the board's single RGB LED between three requesters, e.g. heartbeat, phin activity and error status.
- Grants ownership round-robin with a guaranteed minimum display time per grant.
- Drives the three LED pins with per-requester colour and 8-bit PWM brightness.
- Sits between status sources and the rgb_led_tri_o_* pins in the top-level tracker design.

Parameters:
- HOLD_CYCLES, 16777216, minimum sys_clock cycles a granted requester owns the LED. Legal range 1..2^32-1.
- PWM_BITS, 8, width of the brightness compare counter and of each level field. Fixed at 8 for this revision.

Ports:
- sys_clock  in  1  system clock; all logic on rising edge.
- sys_resetn  in  1  synchronous, active-low reset.
- req  in  3  request per requester; bit i = requester i.
- req_color  in  9  colour per requester: bits [3i+2:3i] = {b,g,r} for requester i.
- req_level  in  24  brightness per requester: bits [8i+7:8i] for requester i.
- grant  out  3  one-hot current owner; 000 when idle.
- busy  out  1  high while any requester owns the LED.
- rgb_led_tri_o_0  out  1  red pin.
- rgb_led_tri_o_1  out  1  green pin.
- rgb_led_tri_o_2  out  1  blue pin.

Behaviour:
- Reset: sys_resetn low at a rising edge clears all state. grant=000, busy=0, all LED pins 0, pwm_cnt=0, hold_cnt=0, state=IDLE, last_grant=2 (so requester 0 wins first). Reset mid-grant aborts the grant on that edge.
- FSM has two states:
  - IDLE: if req!=0, pick the first set bit searching from last_grant+1 mod 3 upward. Set grant one-hot, latch that requester's colour and level, load hold_cnt=HOLD_CYCLES-1, go HOLD. If req==0, stay IDLE.
  - HOLD, hold_cnt!=0: decrement hold_cnt. The owner dropping req has no effect; the grant persists for the full minimum hold.
  - HOLD, hold_cnt==0 (re-arbitration cycle): last_grant=owner, then search from owner+1 over the current req, owner included last.
    - Another requester set: switch grant to it, latch its colour/level, reload hold_cnt.
    - Only the owner set: keep grant, re-latch its colour/level, reload hold_cnt.
    - req==0: grant=000, go IDLE.
- Latency:
  - req sampled at edge N in IDLE gives grant/busy at N+1.
  - LED pins reflect the new owner from N+2; the LED outputs are registered.
- Colour/level are sampled only at grant or renewal. Changes on inputs mid-hold are ignored.
- HOLD_CYCLES=1: re-arbitration every cycle (pure round-robin).
- busy = (grant!=0), registered together with grant.
- PWM:
  - pwm_cnt is an 8-bit free-running counter that wraps 255->0. It runs in all states after reset.
  - Channel c output next cycle = busy & latched_color[c] & (pwm_cnt < latched_level).
  - level=0: always off. level=255: on 255 of every 256 cycles.
- Idle: all LED pins 0 one cycle after busy falls.
- Simultaneous requests in IDLE: the round-robin order decides; exactly one grant bit is ever set.
- hold_cnt is 32 bits unsigned; it never underflows because the reload happens at 0.

Test Plan (HOLD_CYCLES=4 unless stated):
- Reset: hold sys_resetn low 3 cycles with req=111. Required: grant=000, busy=0, pins 000 throughout. Release: grant=001 one cycle later.
- Single requester:
  - Stimulus: req=010, colour1=001 (red), level1=128.
  - Required: grant=010 after 1 cycle. Red pin high exactly 128 of every 256 cycles once settled; green and blue stay 0.
- Round-robin rotation: req=111 held constant. Required: grant sequence 001,010,100,001, each lasting exactly 4 cycles.
- Early drop:
  - Stimulus: req=001 granted, then req deasserted 1 cycle after grant.
  - Required: grant stays 001 for the full 4 cycles, then 000 and busy=0. Pins are 0 the following cycle.
- Level boundaries on one requester, colour 111:
  - level=0: all pins always 0.
  - level=255: each pin low only where pwm_cnt==255, i.e. 1 cycle per 256.
- Renewal and mid-grant reset:
  - Stimulus: req=100 held; colour changed mid-hold.
  - Required: the new colour appears only after renewal at hold expiry, and grant never drops between holds.
  - Then assert sys_resetn low mid-hold. Required: grant=000 and pins 0 on that edge.
